// File: rtl/wvb_rd_arbiter_if.sv
// Readout stream from the waveform-buffer arbiter to the DAQ packetiser.
// One header word per event followed by that event's samples, using a valid/ready handshake.
interface wvb_rd_arbiter_if #(
    parameter int P_HDR_WIDTH = 80,
    parameter int P_CHAN_W    = 2
) ();

    logic [P_HDR_WIDTH-1:0] dout_data;
    logic [P_CHAN_W-1:0]    dout_chan;
    logic                   dout_hdr;
    logic                   dout_last;
    logic                   dout_valid;
    logic                   dout_ready;

    modport master (
        output dout_data,
        output dout_chan,
        output dout_hdr,
        output dout_last,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout_data,
        input  dout_chan,
        input  dout_hdr,
        input  dout_last,
        input  dout_valid,
        output dout_ready
    );

endinterface

// File: rtl/wvb_rd_arbiter.sv
// Round-robin readout arbiter for the waveform buffers.
// Serves one whole event at a time: pops the channel's header, streams the header word,
// then reads samples start..stop (wrapping through address 0) from the shared-address sample RAMs.
module wvb_rd_arbiter #(
    parameter int P_N_CHAN     = 4,
    parameter int P_CHAN_W     = 2,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_HDR_WIDTH  = 80
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [P_N_CHAN-1:0]              hdr_empty,
    output logic [P_N_CHAN-1:0]              hdr_rdreq,
    input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  hdr_data,
    output logic [P_ADR_WIDTH-1:0]           wvb_rd_addr,
    input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data,
    output logic                             busy,
    wvb_rd_arbiter_if.master                 dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HDR_OUT,
        S_RD,
        S_OUT
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [P_CHAN_W-1:0]     rr_ptr;
    logic [P_CHAN_W-1:0]     cur_chan;
    logic [P_HDR_WIDTH-1:0]  hdr_q;
    logic [P_ADR_WIDTH-1:0]  rd_addr;
    logic [P_ADR_WIDTH-1:0]  remaining;

    logic [P_HDR_WIDTH-1:0]  hdr_arr  [P_N_CHAN];
    logic [P_DATA_WIDTH-1:0] samp_arr [P_N_CHAN];
    logic [P_ADR_WIDTH-1:0]  start_addr;
    logic [P_ADR_WIDTH-1:0]  stop_addr;

    logic                    grant_found;
    logic [P_CHAN_W-1:0]     grant_chan;
    logic [P_CHAN_W:0]       cand;
    logic [P_CHAN_W:0]       next_ptr_w;
    logic [P_CHAN_W-1:0]     next_ptr;
    logic                    xfer;
    logic                    is_last;

    // Unpack the flat per-channel header and sample buses into arrays indexed by channel
    always_comb begin
        for (int i = 0; i < P_N_CHAN; i++) begin
            hdr_arr[i]  = hdr_data[i*P_HDR_WIDTH +: P_HDR_WIDTH];
            samp_arr[i] = wvb_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
    end

    assign start_addr = hdr_arr[cur_chan][2*P_ADR_WIDTH-1:P_ADR_WIDTH];
    assign stop_addr  = hdr_arr[cur_chan][P_ADR_WIDTH-1:0];
    assign xfer       = dout.dout_valid & dout.dout_ready;
    assign is_last    = (remaining == '0);
    assign busy       = (state_q != S_IDLE);

    // Round-robin search: first pending channel starting at rr_ptr, wrapping modulo P_N_CHAN
    always_comb begin
        grant_found = 1'b0;
        grant_chan  = '0;
        cand        = '0;
        for (int i = 0; i < P_N_CHAN; i++) begin
            cand = {1'b0, rr_ptr} + (P_CHAN_W+1)'(i);
            if (cand >= (P_CHAN_W+1)'(P_N_CHAN)) begin
                cand = cand - (P_CHAN_W+1)'(P_N_CHAN);
            end
            if (!grant_found && !hdr_empty[cand[P_CHAN_W-1:0]]) begin
                grant_found = 1'b1;
                grant_chan  = cand[P_CHAN_W-1:0];
            end
        end
    end

    // Pointer that follows the granted channel, so the winner drops to lowest priority
    always_comb begin
        next_ptr_w = {1'b0, grant_chan} + (P_CHAN_W+1)'(1);
        if (next_ptr_w >= (P_CHAN_W+1)'(P_N_CHAN)) begin
            next_ptr_w = '0;
        end
        next_ptr = next_ptr_w[P_CHAN_W-1:0];
    end

    // Header pop is a single-cycle one-hot pulse, only from idle and never while in reset
    always_comb begin
        hdr_rdreq = '0;
        if (state_q == S_IDLE && en && grant_found && !rst) begin
            hdr_rdreq[grant_chan] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one event runs to completion before the next arbitration
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en && grant_found) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                state_d = S_HDR_OUT;
            end
            S_HDR_OUT: begin
                if (xfer) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (xfer) begin
                    state_d = is_last ? S_IDLE : S_RD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Event datapath: grant bookkeeping, header capture and the sample address walk
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cur_chan    <= '0;
            hdr_q       <= '0;
            rd_addr     <= '0;
            remaining   <= '0;
            wvb_rd_addr <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en && grant_found) begin
                        cur_chan <= grant_chan;
                        rr_ptr   <= next_ptr;
                    end
                end
                S_HDR: begin
                    hdr_q     <= hdr_arr[cur_chan];
                    rd_addr   <= start_addr;
                    remaining <= stop_addr - start_addr;
                end
                S_HDR_OUT: begin
                    if (xfer) begin
                        wvb_rd_addr <= rd_addr;
                    end
                end
                S_OUT: begin
                    if (xfer && !is_last) begin
                        rd_addr     <= rd_addr + 1'b1;
                        remaining   <= remaining - 1'b1;
                        wvb_rd_addr <= rd_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stream outputs are a function of state; the RAM output is held because the address
    // does not move until the sample transfers, so words stay stable through back-pressure
    always_comb begin
        dout.dout_valid = 1'b0;
        dout.dout_hdr   = 1'b0;
        dout.dout_last  = 1'b0;
        dout.dout_chan  = '0;
        dout.dout_data  = '0;
        case (state_q)
            S_HDR_OUT: begin
                dout.dout_valid = 1'b1;
                dout.dout_hdr   = 1'b1;
                dout.dout_chan  = cur_chan;
                dout.dout_data  = hdr_q;
            end
            S_OUT: begin
                dout.dout_valid = 1'b1;
                dout.dout_last  = is_last;
                dout.dout_chan  = cur_chan;
                dout.dout_data  = P_HDR_WIDTH'(samp_arr[cur_chan]);
            end
            default: begin
            end
        endcase
    end

endmodule
